// File: rtl/div_seq_8bit.sv
// Sequential 8-bit unsigned restoring divider: one trial subtraction per clock, 8 iterations.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor completes one cycle after issue and raises dz_err.
module div_seq_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       dz_err
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring iteration per cycle, iter_q counts down 7..0
  // DONE  | results updated, done pulse; start accepted here as in IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  dsr_q, dsr_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  remo_q, remo_d;
  logic        dz_q, dz_d;

  logic [8:0]  rem_shift;
  logic [8:0]  trial;
  logic [8:0]  rem_nx;
  logic [7:0]  quo_nx;

  always_comb begin
    rem_shift = {rem_q[7:0], quo_q[7]};
    trial     = rem_shift - {1'b0, dsr_q};
    if (!trial[8]) begin
      rem_nx = trial;
      quo_nx = {quo_q[6:0], 1'b1};
    end else begin
      rem_nx = rem_shift;
      quo_nx = {quo_q[6:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          iter_d  = 3'd7;
          rem_d   = 9'd0;
          quo_d   = dividend;
          dsr_d   = divisor;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef DIV_ZERO_TRAP_EN
        if (dsr_q == 8'd0) begin
          // quo_q still holds the untouched dividend on the first RUN cycle
          state_d = DONE;
          quot_d  = 8'hFF;
          remo_d  = quo_q;
          dz_d    = 1'b1;
        end else
`endif
        begin
          rem_d  = rem_nx;
          quo_d  = quo_nx;
          iter_d = iter_q - 3'd1;
          if (iter_q == 3'd0) begin
            state_d = DONE;
            quot_d  = quo_nx;
            remo_d  = rem_nx[7:0];
            dz_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= 3'd0;
      rem_q   <= 9'd0;
      quo_q   <= 8'd0;
      dsr_q   <= 8'd0;
      quot_q  <= 8'd0;
      remo_q  <= 8'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dz_err    = dz_q;

endmodule

// File: tb/tb_div_seq_8bit.sv
// Directed and random self-checking bench for div_seq_8bit.
module tb_div_seq_8bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dz_err;

  int checks;
  int failures;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  div_seq_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz_err    (dz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive start for exactly one rising edge; returns at the falling edge after it.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen (lat = -1 on timeout) and busy cycles on the way.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        return;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 8'h00) begin failures++; $display("FAIL reset_q got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'h00) begin failures++; $display("FAIL reset_r got=%0d exp=0", remainder); end
    checks++; if (dz_err !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(8'd100, 8'd7);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
    wait_done(lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    checks++; if (quotient !== 8'd14) begin failures++; $display("FAIL basic_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 8'd2) begin failures++; $display("FAIL basic_r got=%0d exp=2", remainder); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_boundaries();
    logic [7:0] tv [4][4];
    int lat, bc;
    tv[0] = '{8'd255, 8'd1,   8'd255, 8'd0};
    tv[1] = '{8'd5,   8'd9,   8'd0,   8'd5};
    tv[2] = '{8'd255, 8'd255, 8'd1,   8'd0};
    tv[3] = '{8'd0,   8'd3,   8'd0,   8'd0};
    for (int i = 0; i < 4; i++) begin
      issue(tv[i][0], tv[i][1]);
      wait_done(lat, bc);
      checks++; if (lat !== 8) begin failures++; $display("FAIL bound%0d_latency got=%0d exp=8", i, lat); end
      checks++; if (quotient !== tv[i][2]) begin failures++; $display("FAIL bound%0d_q got=%0d exp=%0d", i, quotient, tv[i][2]); end
      checks++; if (remainder !== tv[i][3]) begin failures++; $display("FAIL bound%0d_r got=%0d exp=%0d", i, remainder, tv[i][3]); end
      dividend = 8'hA5;
      divisor  = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (quotient !== tv[i][2] || remainder !== tv[i][3])
        begin failures++; $display("FAIL bound%0d_hold got=%0d/%0d exp=%0d/%0d", i, quotient, remainder, tv[i][2], tv[i][3]); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    int exp_lat;
    exp_lat = TRAP ? 1 : 8;
    issue(8'd77, 8'd0);
    wait_done(lat, bc);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL dz_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (bc !== exp_lat) begin failures++; $display("FAIL dz_busy_cycles got=%0d exp=%0d", bc, exp_lat); end
    checks++; if (quotient !== 8'hFF) begin failures++; $display("FAIL dz_q got=%0d exp=255", quotient); end
    checks++; if (remainder !== 8'd77) begin failures++; $display("FAIL dz_r got=%0d exp=77", remainder); end
    checks++; if (dz_err !== TRAP) begin failures++; $display("FAIL dz_flag got=%b exp=%b", dz_err, TRAP); end
    @(negedge clk);
    issue(8'd10, 8'd3);
    wait_done(lat, bc);
    checks++; if (quotient !== 8'd3 || remainder !== 8'd1)
      begin failures++; $display("FAIL dz_followup got=%0d/%0d exp=3/1", quotient, remainder); end
    checks++; if (dz_err !== 1'b0) begin failures++; $display("FAIL dz_clear got=%b exp=0", dz_err); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    issue(8'd9, 8'd2);
    wait_done(lat, bc);
    checks++; if (lat !== 4) begin failures++; $display("FAIL proto_ignored_latency got=%0d exp=4", lat); end
    checks++; if (quotient !== 8'd66 || remainder !== 8'd2)
      begin failures++; $display("FAIL proto_ignored_result got=%0d/%0d exp=66/2", quotient, remainder); end
    issue(8'd9, 8'd2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL proto_b2b_accept got=%b exp=1", busy); end
    wait_done(lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL proto_b2b_latency got=%0d exp=8", lat); end
    checks++; if (quotient !== 8'd4 || remainder !== 8'd1)
      begin failures++; $display("FAIL proto_b2b_result got=%0d/%0d exp=4/1", quotient, remainder); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    int done_seen;
    issue(8'd100, 8'd7);
    wait_done(lat, bc);
    @(negedge clk);
    issue(8'd50, 8'd6);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (quotient !== 8'd0 || remainder !== 8'd0)
      begin failures++; $display("FAIL abort_clear got=%0d/%0d exp=0/0", quotient, remainder); end
    done_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    issue(8'd50, 8'd6);
    wait_done(lat, bc);
    checks++; if (lat !== 8 || quotient !== 8'd8 || remainder !== 8'd2)
      begin failures++; $display("FAIL abort_rerun got=lat%0d %0d/%0d exp=lat8 8/2", lat, quotient, remainder); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc;
    int exp_lat;
    int gap;
    logic [7:0] a, b;
    logic [7:0] eq, er;
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) begin
        eq = 8'hFF;
        er = a;
        exp_lat = TRAP ? 1 : 8;
      end else begin
        eq = a / b;
        er = a % b;
        exp_lat = 8;
      end
      issue(a, b);
      wait_done(lat, bc);
      checks++; if (lat !== exp_lat)
        begin failures++; $display("FAIL rand%0d_latency %0d/%0d got=%0d exp=%0d", n, a, b, lat, exp_lat); end
      checks++; if (quotient !== eq || remainder !== er)
        begin failures++; $display("FAIL rand%0d_result %0d/%0d got=%0d/%0d exp=%0d/%0d", n, a, b, quotient, remainder, eq, er); end
      if (b != 8'd0) begin
        checks++; if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || remainder >= b)
          begin failures++; $display("FAIL rand%0d_invariant %0d/%0d got=%0d/%0d", n, a, b, quotient, remainder); end
      end
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
